// File: rtl/count_sequencer.sv
// Run controller for a WIDTH-bit up-counter: counts 0..lim_r, then parks in DONE or wraps.
// All state, including status outputs, is registered on the falling edge of clock_n.
module count_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock_n,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           st;
    logic [WIDTH-1:0] lim_r;

    assign state = st;

    // busy/done are registered alongside st so they never glitch on a state change
    always_ff @(negedge clock_n or posedge reset) begin
        if (reset) begin
            st    <= IDLE;
            q     <= '0;
            lim_r <= '0;
            wrap  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        lim_r <= limit;
                        q     <= '0;
                        st    <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        q    <= '0;
                        st   <= IDLE;
                        busy <= 1'b0;
                    end else if (pause) begin
                        st <= PAUSE;
                    end else if (q != lim_r) begin
                        q <= q + 1'b1;
                    end else begin
                        wrap <= 1'b1;
                        if (auto_reload) begin
                            q <= '0;
                        end else begin
                            st   <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        q    <= '0;
                        st   <= IDLE;
                        busy <= 1'b0;
                    end else if (!pause) begin
                        st <= RUN;
                    end
                end
                DONE: begin
                    // start outranks stop here so a finished run can be re-armed directly
                    if (start) begin
                        lim_r <= limit;
                        q     <= '0;
                        st    <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else if (stop) begin
                        q    <= '0;
                        st   <= IDLE;
                        done <= 1'b0;
                    end
                end
                default: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios plus randomized commands,
// compared against an elapsed-count model (q = active count edges mod (limit+1)).
module tb_count_sequencer;
    localparam int WIDTH = 4;

    logic             clock_n, reset, start, stop, pause, auto_reload;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             busy, done, wrap;
    logic [1:0]       state;

    int vectors, miscompares;
    int m_ph, m_n, m_lim;
    bit m_wrap;

    count_sequencer #(.WIDTH(WIDTH)) dut (
        .clock_n(clock_n), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .limit(limit), .q(q), .busy(busy), .done(done),
        .wrap(wrap), .state(state)
    );

    initial begin
        clock_n = 1'b1;
        forever #5 clock_n = ~clock_n;
    end

    // model phases: 0 idle, 1 run, 2 paused, 3 done
    function automatic void model_reset();
        m_ph = 0; m_n = 0; m_lim = 0; m_wrap = 0;
    endfunction

    function automatic void model_edge();
        m_wrap = 0;
        case (m_ph)
            0: if (start) begin m_lim = int'(limit); m_n = 0; m_ph = 1; end
            1: begin
                if (stop) begin m_ph = 0; m_n = 0; end
                else if (pause) m_ph = 2;
                else if (m_n % (m_lim + 1) != m_lim) m_n++;
                else begin
                    m_wrap = 1;
                    if (auto_reload) m_n++;
                    else m_ph = 3;
                end
            end
            2: begin
                if (stop) begin m_ph = 0; m_n = 0; end
                else if (!pause) m_ph = 1;
            end
            default: begin
                if (start) begin m_lim = int'(limit); m_n = 0; m_ph = 1; end
                else if (stop) begin m_ph = 0; m_n = 0; end
            end
        endcase
    endfunction

    function automatic logic [WIDTH+4:0] exp_vec();
        logic [WIDTH-1:0] qe;
        logic             b, d;
        qe = WIDTH'(m_n % (m_lim + 1));
        b  = (m_ph == 1 || m_ph == 2);
        d  = (m_ph == 3);
        return {qe, 2'(m_ph), b, d, m_wrap};
    endfunction

    task automatic step();
        @(negedge clock_n);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; auto_reload = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs(); limit = '0;
        model_reset();
        #12;
        vectors++;
        if ({q, state, busy, done, wrap} !== exp_vec()) begin
            miscompares++; $display("FAIL reset_init got=%h exp=%h", {q, state, busy, done, wrap}, exp_vec());
        end
        reset = 0;
        limit = 4'd9; start = 1; step(); start = 0;
        repeat (5) step();
        vectors++;
        if (q !== 4'd5 || state !== 2'd1) begin
            miscompares++; $display("FAIL reset_precount got q=%0d st=%0d exp q=5 st=1", q, state);
        end
        @(posedge clock_n); #2 reset = 1; #1;
        model_reset();
        vectors++;
        if ({q, state, busy, done, wrap} !== {4'd0, 2'd0, 3'b000}) begin
            miscompares++; $display("FAIL reset_async got=%h exp=%h", {q, state, busy, done, wrap}, {4'd0, 2'd0, 3'b000});
        end
        #1 reset = 0;
        step();
        vectors++;
        if ({q, state, busy, done, wrap} !== exp_vec()) begin
            miscompares++; $display("FAIL reset_after got=%h exp=%h", {q, state, busy, done, wrap}, exp_vec());
        end
    endtask

    task automatic test_oneshot();
        int wraps;
        wraps = 0;
        idle_inputs(); limit = 4'd3; start = 1; step(); start = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            wraps += int'(wrap);
            vectors++;
            if ({q, state, busy, done, wrap} !== exp_vec()) begin
                miscompares++; $display("FAIL oneshot cyc%0d got=%h exp=%h", i, {q, state, busy, done, wrap}, exp_vec());
            end
        end
        vectors++;
        if (wraps !== 1 || done !== 1'b1 || q !== 4'd3) begin
            miscompares++; $display("FAIL oneshot_end got wraps=%0d done=%b q=%0d exp 1 1 3", wraps, done, q);
        end
        stop = 1; step(); stop = 0;
        vectors++;
        if ({q, state, busy, done, wrap} !== exp_vec()) begin
            miscompares++; $display("FAIL oneshot_stop got=%h exp=%h", {q, state, busy, done, wrap}, exp_vec());
        end
    endtask

    task automatic test_autoreload();
        int wraps;
        wraps = 0;
        idle_inputs(); auto_reload = 1; limit = 4'd2; start = 1; step(); start = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) limit = 4'd7;
            step();
            wraps += int'(wrap);
            vectors++;
            if ({q, state, busy, done, wrap} !== exp_vec()) begin
                miscompares++; $display("FAIL autoreload cyc%0d got=%h exp=%h", i, {q, state, busy, done, wrap}, exp_vec());
            end
        end
        vectors++;
        if (wraps !== 4) begin
            miscompares++; $display("FAIL autoreload_period got wraps=%0d exp 4", wraps);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_pause();
        idle_inputs(); limit = 4'd9; start = 1; step(); start = 0;
        repeat (4) step();
        pause = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({q, state, busy, done, wrap} !== exp_vec() || q !== 4'd4) begin
                miscompares++; $display("FAIL pause_hold cyc%0d got=%h exp=%h", i, {q, state, busy, done, wrap}, exp_vec());
            end
        end
        pause = 0; step();
        vectors++;
        if (q !== 4'd4 || state !== 2'd1) begin
            miscompares++; $display("FAIL pause_resume got q=%0d st=%0d exp q=4 st=1", q, state);
        end
        step();
        vectors++;
        if (q !== 4'd5 || {q, state, busy, done, wrap} !== exp_vec()) begin
            miscompares++; $display("FAIL pause_next got q=%0d exp 5", q);
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_stop_start();
        idle_inputs(); limit = 4'd9; start = 1; step(); start = 0;
        repeat (3) step();
        limit = 4'd2; start = 1;
        repeat (2) step();
        start = 0;
        vectors++;
        if (q !== 4'd5 || {q, state, busy, done, wrap} !== exp_vec()) begin
            miscompares++; $display("FAIL start_in_run got q=%0d exp 5", q);
        end
        stop = 1; pause = 1; step(); stop = 0; pause = 0;
        vectors++;
        if ({q, state, busy, done, wrap} !== {4'd0, 2'd0, 3'b000}) begin
            miscompares++; $display("FAIL stop_pause got=%h exp=%h", {q, state, busy, done, wrap}, {4'd0, 2'd0, 3'b000});
        end
        limit = 4'd1; start = 1; step(); start = 0;
        repeat (3) step();
        vectors++;
        if (state !== 2'd3 || q !== 4'd1) begin
            miscompares++; $display("FAIL done_reach got st=%0d q=%0d exp st=3 q=1", state, q);
        end
        limit = 4'd5; start = 1; stop = 1; step(); start = 0; stop = 0;
        vectors++;
        if ({q, state, busy, done, wrap} !== {4'd0, 2'd1, 3'b100}) begin
            miscompares++; $display("FAIL done_start_stop got=%h exp=%h", {q, state, busy, done, wrap}, {4'd0, 2'd1, 3'b100});
        end
        step();
        vectors++;
        if ({q, state, busy, done, wrap} !== exp_vec()) begin
            miscompares++; $display("FAIL done_restart got=%h exp=%h", {q, state, busy, done, wrap}, exp_vec());
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_limit_edges();
        int wraps;
        wraps = 0;
        idle_inputs(); auto_reload = 1; limit = 4'd0; start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            wraps += int'(wrap);
            vectors++;
            if ({q, state, busy, done, wrap} !== exp_vec()) begin
                miscompares++; $display("FAIL limit0 cyc%0d got=%h exp=%h", i, {q, state, busy, done, wrap}, exp_vec());
            end
        end
        vectors++;
        if (wraps !== 5) begin
            miscompares++; $display("FAIL limit0_wraps got %0d exp 5", wraps);
        end
        stop = 1; step(); stop = 0;
        wraps = 0;
        limit = 4'd15; start = 1; step(); start = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            wraps += int'(wrap);
            vectors++;
            if ({q, state, busy, done, wrap} !== exp_vec()) begin
                miscompares++; $display("FAIL limit15 cyc%0d got=%h exp=%h", i, {q, state, busy, done, wrap}, exp_vec());
            end
        end
        vectors++;
        if (wraps !== 1 || q !== 4'd1) begin
            miscompares++; $display("FAIL limit15_wrap got wraps=%0d q=%0d exp 1 1", wraps, q);
        end
        stop = 1; step(); stop = 0;
        auto_reload = 0; limit = 4'd0; start = 1; step(); start = 0;
        step();
        vectors++;
        if ({q, state, busy, done, wrap} !== {4'd0, 2'd3, 3'b011}) begin
            miscompares++; $display("FAIL limit0_oneshot got=%h exp=%h", {q, state, busy, done, wrap}, {4'd0, 2'd3, 3'b011});
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            start       = ($urandom % 4) == 0;
            stop        = ($urandom % 16) == 0;
            pause       = ($urandom % 6) == 0;
            auto_reload = ($urandom % 2) == 0;
            limit       = WIDTH'($urandom);
            step();
            vectors++;
            if ({q, state, busy, done, wrap} !== exp_vec()) begin
                miscompares++; $display("FAIL random cyc%0d got=%h exp=%h", i, {q, state, busy, done, wrap}, exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_pause();
        test_stop_start();
        test_limit_edges();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
